// File: rtl/i2c_codec_target.sv
// Write-only I2C target modelling the codec control port.
// Decodes 7-bit register address + 9-bit data frames into a shadow file.
module i2c_codec_target #(
    parameter logic [7:0] DEV_ADDR  = 8'h34,
    parameter int         NUM_REGS  = 16,
    parameter logic [6:0] RESET_REG = 7'h0F
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i2c_sclk,
    inout  wire        i2c_sdat,
    output logic       wr_valid,
    output logic [6:0] wr_addr,
    output logic [8:0] wr_data,
    input  logic [3:0] rd_addr,
    output logic [8:0] rd_data,
    output logic [7:0] write_count,
    output logic       busy
);

    localparam int AW = $clog2(NUM_REGS);

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, BYTE1, ACK1, BYTE2, ACK2, IGNORE
    } state_t;

    state_t     state;
    logic       scl_s1, scl_s2, scl_d;
    logic       sda_s1, sda_s2, sda_d;
    logic       sda_oe;
    logic [2:0] bit_cnt;
    logic [7:0] shift;
    logic [7:0] byte1;
    logic       have8;
    logic       addr_ok;
    logic [8:0] regs [NUM_REGS];

    logic       start, stop, scl_rise, scl_fall;
    logic       commit;
    logic [6:0] commit_addr;
    logic [8:0] commit_data;

    assign i2c_sdat = sda_oe ? 1'b0 : 1'bz;

    assign start    = scl_s2 & sda_d & ~sda_s2;
    assign stop     = scl_s2 & ~sda_d & sda_s2;
    assign scl_rise = scl_s2 & ~scl_d;
    assign scl_fall = ~scl_s2 & scl_d;

    assign commit      = (state == BYTE2) && have8 && scl_fall && !start && !stop;
    assign commit_addr = byte1[7:1];
    assign commit_data = {byte1[0], shift};

    // Flops reset to the idle-bus level so reset release never fakes an edge
    always_ff @(posedge clk) begin
        if (reset) begin
            scl_s1 <= 1'b1;
            scl_s2 <= 1'b1;
            scl_d  <= 1'b1;
            sda_s1 <= 1'b1;
            sda_s2 <= 1'b1;
            sda_d  <= 1'b1;
        end else begin
            scl_s1 <= i2c_sclk;
            scl_s2 <= scl_s1;
            scl_d  <= scl_s2;
            sda_s1 <= i2c_sdat;
            sda_s2 <= sda_s1;
            sda_d  <= sda_s2;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            sda_oe      <= 1'b0;
            bit_cnt     <= 3'd0;
            shift       <= 8'd0;
            byte1       <= 8'd0;
            have8       <= 1'b0;
            addr_ok     <= 1'b0;
            busy        <= 1'b0;
            wr_valid    <= 1'b0;
            wr_addr     <= 7'd0;
            wr_data     <= 9'd0;
            write_count <= 8'd0;
        end else begin
            wr_valid <= 1'b0;
            if (start) begin
                state   <= ADDR;
                bit_cnt <= 3'd0;
                have8   <= 1'b0;
                sda_oe  <= 1'b0;
                busy    <= 1'b1;
            end else if (stop) begin
                state  <= IDLE;
                have8  <= 1'b0;
                sda_oe <= 1'b0;
                busy   <= 1'b0;
            end else begin
                if (scl_rise && (state == ADDR || state == BYTE1 || state == BYTE2)) begin
                    shift   <= {shift[6:0], sda_s2};
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7)
                        have8 <= 1'b1;
                end
                if (scl_fall) begin
                    case (state)
                        ADDR: if (have8) begin
                            have8   <= 1'b0;
                            addr_ok <= (shift == DEV_ADDR);
                            sda_oe  <= (shift == DEV_ADDR);
                            state   <= ADDR_ACK;
                        end
                        ADDR_ACK: begin
                            sda_oe  <= 1'b0;
                            bit_cnt <= 3'd0;
                            state   <= addr_ok ? BYTE1 : IGNORE;
                        end
                        BYTE1: if (have8) begin
                            have8  <= 1'b0;
                            byte1  <= shift;
                            sda_oe <= 1'b1;
                            state  <= ACK1;
                        end
                        ACK1: begin
                            sda_oe  <= 1'b0;
                            bit_cnt <= 3'd0;
                            state   <= BYTE2;
                        end
                        BYTE2: if (have8) begin
                            have8       <= 1'b0;
                            sda_oe      <= 1'b1;
                            wr_valid    <= 1'b1;
                            wr_addr     <= commit_addr;
                            wr_data     <= commit_data;
                            write_count <= write_count + 8'd1;
                            state       <= ACK2;
                        end
                        ACK2: begin
                            sda_oe <= 1'b0;
                            state  <= IGNORE;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    // Clearing on RESET_REG wins over the ordinary in-range store
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= 9'd0;
            rd_data <= 9'd0;
        end else begin
            if (commit) begin
                if (commit_addr == RESET_REG) begin
                    for (int i = 0; i < NUM_REGS; i++)
                        regs[i] <= 9'd0;
                end else if ({25'd0, commit_addr} < NUM_REGS) begin
                    regs[commit_addr[AW-1:0]] <= commit_data;
                end
            end
            rd_data <= regs[rd_addr];
        end
    end

endmodule
